i2c_slave_regs: RTL

Parametrised I2C slave with an internal byte register file, the next-generation successor of the board's reduced I2C slave. A single clock domain replaces the divided-clock scheme with a sample-enable tick. A digital glitch filter cleans `scl`/`sda`. The block supports multi-byte auto-incrementing writes and reads, repeated START, and an address set by parameter. It sits at the board top level between the I2C pins and the LED/control logic, which consume the register contents.

---
 rtl/i2c_slave_regs.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C slave with glitch-filtered inputs and an auto-incrementing byte register file
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         NUM_REGS   = 8,
    parameter int         TICK_DIV   = 10,
    parameter int         FILTER_LEN = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  busy,
    output logic                  led
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RD_ACK
    } state_t;

    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                  scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic                  sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic [FILTER_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  rw_q, rw_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];

    logic       tick;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic [PTR_W-1:0] ptr_inc;

    assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    // Filtered lines only move once the whole history window agrees.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        scl_s1_d   = scl;
        scl_s2_d   = scl_s1_q;
        sda_s1_d   = sda;
        sda_s2_d   = sda_s1_q;
        scl_hist_d = scl_hist_q;
        sda_hist_d = sda_hist_q;
        scl_f_d    = scl_f_q;
        sda_f_d    = sda_f_q;
        if (tick) begin
            scl_hist_d = (scl_hist_q << 1) | FILTER_LEN'(scl_s2_q);
            sda_hist_d = (sda_hist_q << 1) | FILTER_LEN'(sda_s2_q);
            if (&scl_hist_d)       scl_f_d = 1'b1;
            else if (~|scl_hist_d) scl_f_d = 1'b0;
            if (&sda_hist_d)       sda_f_d = 1'b1;
            else if (~|sda_hist_d) sda_f_d = 1'b0;
        end
    end

    assign scl_rise  = !scl_f_q &&  scl_f_d;
    assign scl_fall  =  scl_f_q && !scl_f_d;
    assign start_det =  scl_f_q &&  sda_f_q && !sda_f_d;
    assign stop_det  =  scl_f_q && !sda_f_q &&  sda_f_d;
    assign rx_byte   = {shift_q[6:0], sda_f_q};
    assign ptr_inc   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        regs_d    = regs_q;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WRITE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    busy_d = 1'b1;
                                    rw_d   = rx_byte[0];
                                end else begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == PTR) begin
                                if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                    ptr_d = rx_byte[PTR_W-1:0];
                                end else begin
                                    state_d = IDLE;
                                    busy_d  = 1'b0;
                                end
                            end else begin
                                // Committed on the 8th rise so a STOP before the ACK still keeps it.
                                regs_d[ptr_q] = rx_byte;
                                ptr_d         = ptr_inc;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ADDR)     state_d = ADDR_ACK;
                        else if (state_q == PTR) state_d = PTR_ACK;
                        else                     state_d = WR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            ptr_d    = ptr_inc;
                            state_d  = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WRITE;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    // bit_cnt doubles as the "master acknowledged" flag here.
                    if (scl_rise) begin
                        if (sda_f_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        ptr_d     = ptr_inc;
                        bit_cnt_d = '0;
                        state_d   = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_out[8*k +: 8] = regs_q[k];
    end

    assign sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign busy = busy_q;
    assign led  = regs_q[0][0];

endmodule
